// File: rtl/cnn_pset_wr_if.sv
// Host stream and parameter-memory write port
// for the CNN parameter-set writer.
interface cnn_pset_wr_if #(
  parameter int DATA_SIZE = 16,
  parameter int MEM_SIZE  = 16
);
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_ready;
  logic                 ps_we;
  logic [MEM_SIZE-1:0]  ps_wa;
  logic [DATA_SIZE-1:0] ps_wd;

  modport master (
    output in_valid, in_data,
    input  in_ready, ps_we, ps_wa, ps_wd
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ps_we, ps_wa, ps_wd
  );
endinterface

// File: rtl/cnn_pset_wr.sv
// CNN parameter-set writer: streams NPARAM host words into memory.
// Optional checksum word after the set is enabled by PSET_CHK_EN.
module cnn_pset_wr #(
  parameter int DATA_SIZE = 16,
  parameter int MEM_SIZE  = 16,
  parameter int NPARAM    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  cnn_pset_wr_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int CW = $clog2(NPARAM + 1);

`ifdef PSET_CHK_EN
  typedef enum logic [1:0] {IDLE, WRITE, CHK, FIN} st_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, FIN} st_t;
`endif

  st_t           state, nxt;
  logic [CW-1:0] cnt;
  logic          rdy;
  logic          last;

  assign last         = (cnt == CW'(NPARAM - 1));
  assign bus.in_ready = rdy;
  assign busy         = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state and ready; ready depends on state only
  always_comb begin
    nxt = state;
    rdy = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = WRITE;
      WRITE: begin
        rdy = 1'b1;
`ifdef PSET_CHK_EN
        if (bus.in_valid && last) nxt = CHK;
`else
        if (bus.in_valid && last) nxt = FIN;
`endif
      end
`ifdef PSET_CHK_EN
      CHK: begin
        rdy = 1'b1;
        if (bus.in_valid) nxt = FIN;
      end
`endif
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

`ifdef PSET_CHK_EN
  logic [DATA_SIZE-1:0] sum;

  // running checksum and mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          sum <= '0;
          err <= 1'b0;
        end
        WRITE: if (bus.in_valid) sum <= sum + bus.in_data;
        CHK: if (bus.in_valid) err <= (bus.in_data != sum);
        default: ;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

  // word counter, memory write port and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bus.ps_we <= 1'b0;
      bus.ps_wa <= '0;
      bus.ps_wd <= '0;
      done      <= 1'b1;
    end else begin
      bus.ps_we <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          cnt  <= '0;
          done <= 1'b0;
        end
        WRITE: if (bus.in_valid) begin
          bus.ps_we <= 1'b1;
          bus.ps_wa <= MEM_SIZE'(BASE_ADDR) + MEM_SIZE'(cnt);
          bus.ps_wd <= bus.in_data;
          cnt       <= cnt + CW'(1);
        end
        FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_pset_wr.sv
// Scoreboard bench for cnn_pset_wr: randomized loads checked
// against a queue of expected memory writes and load timing.
module tb_cnn_pset_wr;
  localparam int NP   = 12;
  localparam int BASE = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  cnn_pset_wr_if #(.DATA_SIZE(16), .MEM_SIZE(16)) bus ();

  cnn_pset_wr #(
    .DATA_SIZE(16), .MEM_SIZE(16),
    .NPARAM(NP), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  wr_t exp_q[$];
  int exp_dly = 1;
  int last_we = 0;
  logic done_q = 1'b1;

  logic [15:0] wv[NP];
  int gap[NP];
  int xstart;
  bit sv;
  logic [15:0] ckw;
  int ckg;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: every write pops the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ps_we) begin
        last_we = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {bus.ps_wa, bus.ps_wd}, 32'h0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.ps_wa), 32'(e.a));
          chk("wr_data", 32'(bus.ps_wd), 32'(e.d));
        end
      end
      if (done && !done_q)
        chk("done_after_we", 32'(cyc - last_we), 32'(exp_dly));
      if (done && busy) chk("done_busy_excl", 32'd1, 32'd0);
    end
    done_q = done;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_we"}, 32'(bus.ps_we), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wa"}, 32'(bus.ps_wa), 32'd0);
    chk({tag, "_wd"}, 32'(bus.ps_wd), 32'd0);
  endtask

  task automatic handshake(input string nm);
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    start = 1'b0;
  endtask

  task automatic run_load(input string nm, input int abort_after);
    int t0, k, gsum, exp_lat;
    logic [15:0] s;
    logic exp_err;
    s = 16'h0;
    gsum = 0;
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back('{a: 16'(BASE + i), d: wv[i]});
      s = s + wv[i];
      gsum += gap[i];
    end
    exp_err = 1'b0;
    exp_lat = NP + 1 + gsum;
    exp_dly = 1;
`ifdef PSET_CHK_EN
    exp_err = (s != ckw);
    exp_lat += 1 + ckg;
    exp_dly = 2 + ckg;
`endif
    @(negedge clk);
    start = 1'b1;
    if (sv) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hDEAD;
    end
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < NP; i++) begin
      repeat (gap[i]) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = wv[i];
      start = (i == xstart);
      handshake(nm);
      if (abort_after == i + 1) begin
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({nm, "_left"}, 32'(exp_q.size()), 32'(NP - abort_after));
        exp_q.delete();
        chk_reset_vals({nm, "_rst"});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
`ifdef PSET_CHK_EN
    repeat (ckg) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = ckw;
    handshake(nm);
`endif
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic setup_seq(input logic [15:0] base_w);
    logic [15:0] s;
    s = 16'h0;
    for (int i = 0; i < NP; i++) begin
      wv[i] = base_w + 16'(i);
      s = s + wv[i];
      gap[i] = 0;
    end
    xstart = -1;
    sv = 1'b0;
    ckw = s;
    ckg = 0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");

    setup_seq(16'd1);
    run_load("seq", -1);

    setup_seq(16'd1);
    gap[5] = 3;
    run_load("gap", -1);

    setup_seq(16'd1);
    xstart = 5;
    sv = 1'b1;
    run_load("restart", -1);

    setup_seq(16'd1);
    run_load("abort", 7);

    setup_seq(16'h0);
    for (int i = 0; i < NP; i++) wv[i] = 16'hA5;
    ckw = 16'(16'hA5 * NP);
    run_load("a5", -1);

`ifdef PSET_CHK_EN
    setup_seq(16'd1);
    ckw = 16'd77;
    run_load("badsum", -1);
    setup_seq(16'd1);
    chk("sum78", 32'(ckw), 32'd78);
    run_load("goodsum", -1);
`endif

    for (int r = 0; r < 6; r++) begin
      logic [15:0] s;
      s = 16'h0;
      for (int i = 0; i < NP; i++) begin
        wv[i] = 16'($urandom);
        s = s + wv[i];
        gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      xstart = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NP - 1) : -1;
      sv = 1'($urandom_range(0, 1));
      ckg = $urandom_range(0, 2);
      ckw = ($urandom_range(0, 1) == 1) ? s : s ^ 16'(1 << $urandom_range(0, 15));
      run_load("rand", -1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
